// File: rtl/washer_ctrl_gen2.sv
`timescale 1ns/1ps
// Washing-machine sequencer: fill/wash/drain, N rinse loops, spin, with pause
// context retention, door safety, soap-wait timeout and remaining-time count.
module washer_ctrl_gen2 #(
  parameter int unsigned TW      = 8,
  parameter int unsigned FILL_T  = 2,
  parameter int unsigned WASH_T  = 3,
  parameter int unsigned DRAIN_T = 2,
  parameter int unsigned RINSE_T = 3,
  parameter int unsigned SPIN_T  = 4,
  parameter int unsigned N_RINSE = 2,
  parameter int unsigned SOAP_TO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  input  logic          pause,
  input  logic          door_closed,
  input  logic          soap,
  input  logic [2:0]    program_sel,
  output logic          valve_cold,
  output logic          valve_hot,
  output logic          valve_out,
  output logic          soap_in,
  output logic [1:0]    motor,
  output logic          lock_door,
  output logic          soap_warning,
  output logic          busy,
  output logic          program_done,
  output logic          error,
  output logic [TW-1:0] remaining,
  output logic [3:0]    phase
);

  localparam int unsigned SW         = (SOAP_TO > 1) ? $clog2(SOAP_TO) : 1;
  localparam int unsigned TOTAL_RS   = N_RINSE * (RINSE_T + DRAIN_T) + SPIN_T;
  localparam int unsigned TOTAL_FULL = FILL_T + WASH_T + DRAIN_T + TOTAL_RS;

  localparam logic [2:0] P_COLD  = 3'd0;
  localparam logic [2:0] P_HOT   = 3'd1;
  localparam logic [2:0] P_RINSE = 3'd2;
  localparam logic [2:0] P_SPIN  = 3'd3;
  localparam logic [2:0] P_WARM  = 3'd4;

  if (TOTAL_FULL >= (1 << TW)) begin : g_tw_check
    $error("washer_ctrl_gen2: program total does not fit in TW bits");
  end

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_WAIT_SOAP = 4'd2,
    S_WASH      = 4'd3,
    S_DRAIN_W   = 4'd4,
    S_RINSE     = 4'd5,
    S_DRAIN_R   = 4'd6,
    S_SPIN      = 4'd7,
    S_PAUSED    = 4'd8,
    S_DONE      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  state_t        state, state_d, saved, saved_d;
  logic [TW-1:0] phase_cnt, phase_d, rem_d;
  logic [3:0]    rinse_cnt, rinse_d;
  logic [2:0]    prog, prog_d;
  logic [SW-1:0] soap_cnt, soap_d;
  logic          start_q;
  logic          start_ev, sel_legal, last_rinse;

  function automatic logic [TW-1:0] phase_init(input state_t s);
    case (s)
      S_FILL:               return TW'(FILL_T - 1);
      S_WASH:               return TW'(WASH_T - 1);
      S_DRAIN_W, S_DRAIN_R: return TW'(DRAIN_T - 1);
      S_RINSE:              return TW'(RINSE_T - 1);
      S_SPIN:               return TW'(SPIN_T - 1);
      default:              return '0;
    endcase
  endfunction

  assign start_ev   = start & ~start_q;
  assign sel_legal  = (program_sel <= P_WARM);
  assign last_rinse = (rinse_cnt >= 4'(N_RINSE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      saved     <= S_IDLE;
      phase_cnt <= '0;
      remaining <= '0;
      rinse_cnt <= '0;
      prog      <= '0;
      soap_cnt  <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_d;
      saved     <= saved_d;
      phase_cnt <= phase_d;
      remaining <= rem_d;
      rinse_cnt <= rinse_d;
      prog      <= prog_d;
      soap_cnt  <= soap_d;
      start_q   <= start;
    end
  end

  // Next state: power loss dominates, then pause/door, then phase expiry.
  always_comb begin
    state_d = state;
    saved_d = saved;
    phase_d = phase_cnt;
    rem_d   = remaining;
    rinse_d = rinse_cnt;
    prog_d  = prog;
    soap_d  = soap_cnt;
    if (!power) begin
      state_d = S_IDLE;
      saved_d = S_IDLE;
      phase_d = '0;
      rem_d   = '0;
      rinse_d = '0;
      soap_d  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ev && door_closed && sel_legal) begin
            prog_d  = program_sel;
            rinse_d = '0;
            soap_d  = '0;
            case (program_sel)
              P_RINSE: begin
                rem_d   = TW'(TOTAL_RS);
                state_d = S_RINSE;
              end
              P_SPIN: begin
                rem_d   = TW'(SPIN_T);
                state_d = S_SPIN;
              end
              default: begin
                rem_d   = TW'(TOTAL_FULL);
                state_d = soap ? S_FILL : S_WAIT_SOAP;
              end
            endcase
            phase_d = phase_init(state_d);
          end
        end
        S_WAIT_SOAP: begin
          if (soap) begin
            state_d = S_FILL;
            phase_d = phase_init(S_FILL);
          end else if (soap_cnt == SW'(SOAP_TO - 1)) begin
            state_d = S_ERROR;
          end else begin
            soap_d = soap_cnt + SW'(1);
          end
        end
        S_FILL, S_WASH, S_DRAIN_W, S_RINSE, S_DRAIN_R, S_SPIN: begin
          if (pause || !door_closed) begin
            saved_d = state;
            state_d = S_PAUSED;
          end else begin
            rem_d = remaining - TW'(1);
            if (phase_cnt != '0) begin
              phase_d = phase_cnt - TW'(1);
            end else begin
              case (state)
                S_FILL:    state_d = S_WASH;
                S_WASH:    state_d = S_DRAIN_W;
                S_DRAIN_W: state_d = S_RINSE;
                S_RINSE:   state_d = S_DRAIN_R;
                S_DRAIN_R: state_d = last_rinse ? S_SPIN : S_RINSE;
                default:   state_d = S_DONE;
              endcase
              if (state == S_DRAIN_R && !last_rinse) rinse_d = rinse_cnt + 4'd1;
              phase_d = phase_init(state_d);
            end
          end
        end
        S_PAUSED: begin
          if (!pause && door_closed) state_d = saved;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Drivers decoded from state and the captured program.
  always_comb begin
    valve_cold   = 1'b0;
    valve_hot    = 1'b0;
    valve_out    = 1'b0;
    soap_in      = 1'b0;
    motor        = 2'b00;
    lock_door    = 1'b0;
    soap_warning = 1'b0;
    program_done = 1'b0;
    error        = 1'b0;
    case (state)
      S_FILL: begin
        soap_in    = 1'b1;
        valve_cold = (prog == P_COLD) || (prog == P_WARM);
        valve_hot  = (prog == P_HOT) || (prog == P_WARM);
        lock_door  = 1'b1;
      end
      S_WAIT_SOAP: begin
        soap_warning = 1'b1;
        lock_door    = 1'b1;
      end
      S_WASH: begin
        motor     = 2'b01;
        lock_door = 1'b1;
      end
      S_DRAIN_W, S_DRAIN_R: begin
        valve_out = 1'b1;
        lock_door = 1'b1;
      end
      S_RINSE: begin
        valve_cold = 1'b1;
        lock_door  = 1'b1;
      end
      S_SPIN: begin
        motor     = 2'b10;
        lock_door = 1'b1;
      end
      S_PAUSED: lock_door = 1'b1;
      S_DONE:   program_done = 1'b1;
      S_ERROR: begin
        error        = 1'b1;
        soap_warning = 1'b1;
        valve_out    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign phase = 4'(state);

endmodule

// File: tb/tb_washer_ctrl_gen2.sv
`timescale 1ns/1ps
// Directed bench for washer_ctrl_gen2: vector table for full programs plus
// hand sequences for pause, held start, door-open pause and async reset.
module tb_washer_ctrl_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       power, start, pause, door_closed, soap;
  logic [2:0] program_sel;
  logic       valve_cold, valve_hot, valve_out, soap_in;
  logic [1:0] motor;
  logic       lock_door, soap_warning, busy, program_done, error;
  logic [7:0] remaining;
  logic [3:0] phase;
  logic [10:0] outs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  washer_ctrl_gen2 dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .pause(pause),
    .door_closed(door_closed), .soap(soap), .program_sel(program_sel),
    .valve_cold(valve_cold), .valve_hot(valve_hot), .valve_out(valve_out),
    .soap_in(soap_in), .motor(motor), .lock_door(lock_door),
    .soap_warning(soap_warning), .busy(busy), .program_done(program_done),
    .error(error), .remaining(remaining), .phase(phase)
  );

  assign outs = {valve_cold, valve_hot, valve_out, soap_in, motor, lock_door,
                 soap_warning, busy, program_done, error};

  // {vc, vh, vo, soap_in, motor[1:0], lock, warn, busy, done, err}
  localparam logic [10:0] O_IDLE  = 11'b0_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] O_FILLC = 11'b1_0_0_1_00_1_0_1_0_0;
  localparam logic [10:0] O_FILLH = 11'b0_1_0_1_00_1_0_1_0_0;
  localparam logic [10:0] O_FILLW = 11'b1_1_0_1_00_1_0_1_0_0;
  localparam logic [10:0] O_WASH  = 11'b0_0_0_0_01_1_0_1_0_0;
  localparam logic [10:0] O_DRAIN = 11'b0_0_1_0_00_1_0_1_0_0;
  localparam logic [10:0] O_RINSE = 11'b1_0_0_0_00_1_0_1_0_0;
  localparam logic [10:0] O_SPIN  = 11'b0_0_0_0_10_1_0_1_0_0;
  localparam logic [10:0] O_DONE  = 11'b0_0_0_0_00_0_0_1_1_0;
  localparam logic [10:0] O_WAIT  = 11'b0_0_0_0_00_1_1_1_0_0;
  localparam logic [10:0] O_ERR   = 11'b0_0_1_0_00_0_1_1_0_1;
  localparam logic [10:0] O_PAUSE = 11'b0_0_0_0_00_1_0_1_0_0;

  // {power, start, pause, door_closed, soap, program_sel[2:0]}
  localparam logic [7:0] C_RUN      = 8'b1_0_0_1_1_000;
  localparam logic [7:0] C_START    = 8'b1_1_0_1_1_000;
  localparam logic [7:0] ILL_START  = 8'b1_1_0_1_1_110;
  localparam logic [7:0] ILL        = 8'b1_0_0_1_1_110;
  localparam logic [7:0] DOOR_START = 8'b1_1_0_0_1_000;
  localparam logic [7:0] H_NOSOAP   = 8'b1_0_0_1_0_001;
  localparam logic [7:0] H_START_NS = 8'b1_1_0_1_0_001;
  localparam logic [7:0] H_SOAP     = 8'b1_0_0_1_1_001;
  localparam logic [7:0] H_OFF      = 8'b0_0_0_1_1_001;

  typedef struct {
    logic [7:0]  in;
    logic [3:0]  ph;
    logic [7:0]  rm;
    logic [10:0] o;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic [7:0] in, input logic [3:0] ph, input int rm,
                      input logic [10:0] o, input string nm);
    vec_t v;
    v.in = in; v.ph = ph; v.rm = 8'(rm); v.o = o; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [3:0] ph, input logic [7:0] rm,
                       input logic [10:0] o);
    n_vec++;
    if (phase !== ph || remaining !== rm || outs !== o) begin
      n_err++;
      $display("FAIL %s: got phase=%0d remaining=%0d outs=%b, want phase=%0d remaining=%0d outs=%b",
               nm, phase, remaining, outs, ph, rm, o);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  int n_done, first_done;

  initial begin
    rst = 1'b1; power = 1'b0; start = 1'b0; pause = 1'b0;
    door_closed = 1'b1; soap = 1'b1; program_sel = 3'd0;

    // Cold wash: 21 timed cycles then DONE
    push(C_START, 4'd1, 21, O_FILLC, "cold_fill");
    push(C_RUN,   4'd1, 20, O_FILLC, "cold_fill");
    for (int k = 0; k < 3; k++) push(C_RUN, 4'd3, 19 - k, O_WASH, "cold_wash");
    for (int k = 0; k < 2; k++) push(C_RUN, 4'd4, 16 - k, O_DRAIN, "cold_drain_w");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) push(C_RUN, 4'd5, 14 - 5*r - k, O_RINSE, "cold_rinse");
      for (int k = 0; k < 2; k++) push(C_RUN, 4'd6, 11 - 5*r - k, O_DRAIN, "cold_drain_r");
    end
    for (int k = 0; k < 4; k++) push(C_RUN, 4'd7, 4 - k, O_SPIN, "cold_spin");
    push(C_RUN, 4'd9, 0, O_DONE, "cold_done");
    push(C_RUN, 4'd0, 0, O_IDLE, "cold_idle");
    // Illegal program and open door ignore start
    push(ILL_START,  4'd0, 0, O_IDLE, "illegal_sel");
    push(ILL,        4'd0, 0, O_IDLE, "illegal_idle");
    push(DOOR_START, 4'd0, 0, O_IDLE, "door_open_start");
    push(C_RUN,      4'd0, 0, O_IDLE, "door_open_idle");
    // Hot wash, soap arrives on the fifth WAIT_SOAP cycle
    push(H_NOSOAP,   4'd0, 0, O_IDLE, "hot_idle");
    push(H_START_NS, 4'd2, 21, O_WAIT, "hot_wait");
    for (int k = 0; k < 4; k++) push(H_NOSOAP, 4'd2, 21, O_WAIT, "hot_wait");
    push(H_SOAP, 4'd1, 21, O_FILLH, "hot_fill");
    push(H_SOAP, 4'd1, 20, O_FILLH, "hot_fill");
    push(H_OFF,  4'd0, 0, O_IDLE, "hot_power_off");
    // Soap timeout: 16 WAIT_SOAP cycles then ERROR until power drops
    push(H_NOSOAP,   4'd0, 0, O_IDLE, "to_idle");
    push(H_START_NS, 4'd2, 21, O_WAIT, "to_wait");
    for (int k = 0; k < 15; k++) push(H_NOSOAP, 4'd2, 21, O_WAIT, "to_wait");
    push(H_NOSOAP, 4'd10, 21, O_ERR, "to_error");
    push(H_NOSOAP, 4'd10, 21, O_ERR, "to_error_hold");
    push(H_OFF,    4'd0, 0, O_IDLE, "to_power_off");

    step();
    step();
    check("reset_state", 4'd0, 8'd0, O_IDLE);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      {power, start, pause, door_closed, soap, program_sel} = vecs[i].in;
      step();
      check(vecs[i].name, vecs[i].ph, vecs[i].rm, vecs[i].o);
    end

    // Spin only with start held: a single completion
    power = 1'b1; door_closed = 1'b1; soap = 1'b1; pause = 1'b0; start = 1'b0;
    program_sel = 3'd3;
    step();
    start = 1'b1;
    n_done = 0; first_done = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) check("spin_entry", 4'd7, 8'd4, O_SPIN);
      if (program_done) begin
        n_done++;
        if (first_done == 0) first_done = i;
      end
    end
    check_int("spin_done_count", n_done, 1);
    check_int("spin_done_cycle", first_done, 5);
    start = 1'b0;
    step();

    // Warm wash with pause held for 7 cycles from WASH phase count 1
    program_sel = 3'd4; start = 1'b1;
    step();
    check("warm_fill", 4'd1, 8'd21, O_FILLW);
    start = 1'b0;
    for (int i = 2; i <= 30; i++) begin
      pause = (i >= 5 && i <= 11);
      step();
      case (i)
        4:  check("warm_wash_pc1", 4'd3, 8'd18, O_WASH);
        5:  check("warm_paused", 4'd8, 8'd18, O_PAUSE);
        11: check("warm_paused_end", 4'd8, 8'd18, O_PAUSE);
        12: check("warm_resume", 4'd3, 8'd18, O_WASH);
        13: check("warm_wash_last", 4'd3, 8'd17, O_WASH);
        14: check("warm_drain", 4'd4, 8'd16, O_DRAIN);
        29: check("warm_spin_last", 4'd7, 8'd1, O_SPIN);
        30: check("warm_done", 4'd9, 8'd0, O_DONE);
        default: ;
      endcase
    end
    pause = 1'b0;
    step();

    // Rinse+spin: door opens in DRAIN_R, then power loss while paused
    program_sel = 3'd2; start = 1'b1;
    step();
    check("rs_rinse", 4'd5, 8'd14, O_RINSE);
    start = 1'b0;
    step(); step(); step();
    check("rs_drain_r", 4'd6, 8'd11, O_DRAIN);
    door_closed = 1'b0;
    step();
    check("rs_door_pause", 4'd8, 8'd11, O_PAUSE);
    power = 1'b0;
    step();
    check("rs_power_off", 4'd0, 8'd0, O_IDLE);
    power = 1'b1; door_closed = 1'b1;
    step();

    // Asynchronous reset in the middle of SPIN
    program_sel = 3'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre_reset_spin", 4'd7, 8'd3, O_SPIN);
    #2 rst = 1'b1;
    #1 check("async_reset", 4'd0, 8'd0, O_IDLE);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_idle", 4'd0, 8'd0, O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
